// File: rtl/score_add_sequencer.sv
// score_add_sequencer: queues line-clear events and adds them digit-serially into a saturating 4-digit BCD score.
// Define SCORE_HISCORE_EN to keep a best-score register on hi_score; otherwise hi_score is tied to zero.
module score_add_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        clr_valid,
  output logic        clr_ready,
  input  logic [1:0]  clr_lines,
  output logic [15:0] score,
  output logic        busy,
  output logic        score_upd,
  output logic [15:0] hi_score
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [15:0] r_score, r_work, r_opnd;
  logic [1:0]  r_k;
  logic        r_carry, r_upd;
  logic        w_empty, w_full, w_push, w_pop, w_dc;
  logic [1:0]  w_head;
  logic [15:0] w_points, w_new;
  logic [3:0]  w_a, w_b, w_dig;
  logic [4:0]  w_dsum;
  // Extra pointer MSB tells full from empty when the index bits match.
  assign w_empty   = r_wptr == r_rptr;
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign clr_ready = !w_full;
  assign w_push    = clr_valid && !w_full && !new_game;
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !new_game;
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_points  = (w_head == 2'd0) ? 16'h0001 :
                     (w_head == 2'd1) ? 16'h0004 :
                     (w_head == 2'd2) ? 16'h0009 : 16'h0016;
  assign w_a       = r_work[{r_k, 2'b00} +: 4];
  assign w_b       = r_opnd[{r_k, 2'b00} +: 4];
  assign w_dsum    = {1'b0, w_a} + {1'b0, w_b} + {4'b0, r_carry};
  assign w_dc      = w_dsum > 5'd9;
  assign w_dig     = w_dc ? w_dsum[3:0] + 4'd6 : w_dsum[3:0];
  assign w_new     = r_carry ? 16'h9999 : r_work;
  assign score     = r_score;
  assign score_upd = r_upd;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (new_game) w_next = S_IDLE;
    else w_next = (r_state == S_IDLE) ? (w_pop ? S_ADD : S_IDLE) :
                  (r_state == S_ADD)  ? ((r_k == 2'd3) ? S_COMMIT : S_ADD) : S_IDLE;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= clr_lines;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_score <= '0;
      r_work  <= '0;
      r_opnd  <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_upd   <= 1'b0;
    end else if (new_game) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_score <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= r_state == S_COMMIT;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) begin
        r_rptr  <= r_rptr + (AW+1)'(1);
        r_opnd  <= w_points;
        r_work  <= r_score;
        r_carry <= 1'b0;
        r_k     <= '0;
      end
      if (r_state == S_ADD) begin
        r_work[{r_k, 2'b00} +: 4] <= w_dig;
        r_carry <= w_dc;
        r_k     <= r_k + 2'd1;
      end
      if (r_state == S_COMMIT) r_score <= w_new;
    end
  end
`ifdef SCORE_HISCORE_EN
  logic [15:0] r_hi;
  // Valid BCD orders the same as binary, so a plain compare is digit-MS-first.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_hi <= '0;
    else if (!new_game && r_state == S_COMMIT && w_new > r_hi) r_hi <= w_new;
  assign hi_score = r_hi;
`else
  assign hi_score = 16'h0000;
`endif
endmodule

// File: tb/tb_score_add_sequencer.sv
// tb_score_add_sequencer: directed events with a decimal score model feeding a scoreboard checked on score_upd.
module tb_score_add_sequencer;
  logic        clk = 0, rst = 1, new_game = 0, clr_valid = 0;
  logic [1:0]  clr_lines = 0;
  logic        clr_ready, busy, score_upd;
  logic [15:0] score, hi_score;
  typedef struct {logic [15:0] s; logic [15:0] h;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, exp_sc = 0, exp_hi = 0, n_upd = 0;
  logic saw_full = 0;

  score_add_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .clr_valid(clr_valid), .clr_ready(clr_ready),
    .clr_lines(clr_lines), .score(score), .busy(busy), .score_upd(score_upd), .hi_score(hi_score));

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int pts(input logic [1:0] l);
    return (l == 0) ? 1 : (l == 1) ? 4 : (l == 2) ? 9 : 16;
  endfunction

  function automatic logic [15:0] hi_exp();
`ifdef SCORE_HISCORE_EN
    return bcd(exp_hi);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && clr_valid && !clr_ready) saw_full <= 1;
    if (!rst && score_upd) begin
      n_upd++;
      if (q.size() == 0) check("unexpected_upd", 16'h1, 16'h0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("upd_score", score, e.s);
        check("upd_hi", hi_score, e.h);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with clr_valid still high.
  task automatic send(input logic [1:0] l);
    int t = 0;
    exp_t e;
    clr_valid = 1;
    clr_lines = l;
    while (!clr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!clr_ready) check("send_timeout", 16'h0, 16'h1);
    else begin
      exp_sc = (exp_sc + pts(l) > 9999) ? 9999 : exp_sc + pts(l);
      if (exp_sc > exp_hi) exp_hi = exp_sc;
      e.s = bcd(exp_sc);
      e.h = hi_exp();
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    clr_valid = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, "_idle"}, {15'b0, busy}, 16'h0);
    @(negedge clk);
    check({name, "_score"}, score, bcd(exp_sc));
  endtask

  initial begin
    #3;
    check("rst_score", score, 16'h0);
    check("rst_busy", {15'b0, busy}, 16'h0);
    check("rst_upd", {15'b0, score_upd}, 16'h0);
    check("rst_ready", {15'b0, clr_ready}, 16'h1);
    check("rst_hi", hi_score, 16'h0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    // Latency: accepted at edge 0, result at edge 6, idle by edge 7.
    send(2'b00);
    clr_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("lat_no_upd", {15'b0, score_upd}, 16'h0);
      check("lat_hold", score, 16'h0);
      if (i == 1) check("lat_busy", {15'b0, busy}, 16'h1);
    end
    @(negedge clk);
    check("lat_upd", {15'b0, score_upd}, 16'h1);
    check("lat_score", score, 16'h0001);
    @(negedge clk);
    check("lat_busy_low", {15'b0, busy}, 16'h0);
    check("lat_upd_low", {15'b0, score_upd}, 16'h0);
    // Carry chain: 1 + 6*16 = 97, then +4 = 101.
    for (int i = 0; i < 6; i++) send(2'b11);
    wait_idle("pre96");
    check("s97", score, 16'h0097);
    send(2'b01);
    wait_idle("carry");
    check("s101", score, 16'h0101);
    // Saturation.
    while (exp_sc + 16 <= 9990) send(2'b11);
    while (exp_sc < 9990) send(2'b00);
    wait_idle("pre9990");
    check("s9990", score, 16'h9990);
    send(2'b11);
    wait_idle("sat");
    check("sat9999", score, 16'h9999);
    send(2'b00);
    wait_idle("sat_hold");
    check("sat_hold", score, 16'h9999);
    // Back-to-back burst from zero.
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    exp_sc = 0;
    check("ng_score", score, 16'h0);
    check("ng_hi", hi_score, hi_exp());
    n_upd = 0;
    saw_full = 0;
    send(2'b00); send(2'b01); send(2'b10); send(2'b11); send(2'b11); send(2'b01);
    wait_idle("burst");
    check("burst_sum", score, 16'h0050);
    check("burst_full_seen", {15'b0, saw_full}, 16'h1);
    check("burst_upds", 16'(n_upd), 16'd6);
    check("burst_q_empty", 16'(q.size()), 16'd0);
    // new_game mid-ADD with two queued; the offer on that edge is dropped.
    send(2'b11); send(2'b11); send(2'b10);
    new_game = 1;
    @(negedge clk);
    new_game = 0;
    clr_valid = 0;
    q.delete();
    exp_sc = 0;
    n_upd = 0;
    check("ngadd_score", score, 16'h0);
    check("ngadd_busy", {15'b0, busy}, 16'h0);
    check("ngadd_ready", {15'b0, clr_ready}, 16'h1);
    check("ngadd_hi", hi_score, hi_exp());
    repeat (12) @(negedge clk);
    check("ngadd_no_upd", 16'(n_upd), 16'd0);
    check("ngadd_still_empty", {15'b0, busy}, 16'h0);
    // Asynchronous reset mid-ADD.
    send(2'b11); send(2'b11);
    wait_idle("pre_rst");
    check("s32", score, 16'h0032);
    send(2'b11);
    clr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_score", score, 16'h0);
    check("arst_busy", {15'b0, busy}, 16'h0);
    check("arst_upd", {15'b0, score_upd}, 16'h0);
    check("arst_ready", {15'b0, clr_ready}, 16'h1);
    check("arst_hi", hi_score, 16'h0);
    q.delete();
    exp_sc = 0;
    exp_hi = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    send(2'b01);
    wait_idle("post_rst");
    check("post_rst_score", score, 16'h0004);
    check("post_rst_hi", hi_score, hi_exp());
    check("final_q_empty", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
